// File: rtl/ts_event_reader_if.sv
// Bus between ts_event_reader and its bench/monitor: control, event input and FWFT read side.
// The design connects to the slave modport and the driver connects to the master modport.
interface ts_event_reader_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             enable;
  logic             event_in;
  logic             rd_en;
  logic             clr_ovf;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport master (
    output enable, event_in, rd_en, clr_ovf,
    input  rd_data, rd_valid, level, overflow
  );

  modport slave (
    input  enable, event_in, rd_en, clr_ovf,
    output rd_data, rd_valid, level, overflow
  );
endinterface

// File: rtl/ts_event_reader.sv
// Measures the spacing between rising edges of an asynchronous event, in prescaled time
// units, and queues the intervals in a small first-word-fall-through FIFO.
module ts_event_reader #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  ts_event_reader_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // The edge cycle is the first cycle of the new interval, so I clocks read floor(I/PRESCALE).
  localparam logic [PSC_W-1:0] PSC_RESTART = PSC_W'(1 % PRESCALE);
  localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'((PRESCALE == 1) ? 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_c, tick_c, push_c;

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             full_c, pop_c, wr_c;

  // Two-flop synchroniser plus a history flop for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.event_in};
    end
  end

  assign edge_c = sync_q[1] & ~sync_q[2];
  assign tick_c = (psc_q == PSC_W'(PRESCALE - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      psc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    psc_d   = '0;
    cnt_d   = '0;
    push_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = ARMED;
      end
      ARMED: begin
        if (edge_c) begin
          state_d = RUNNING;
          psc_d   = PSC_RESTART;
          cnt_d   = CNT_RESTART;
        end
      end
      RUNNING: begin
        if (edge_c) begin
          push_c = 1'b1;
          psc_d  = PSC_RESTART;
          cnt_d  = CNT_RESTART;
        end else begin
          psc_d = tick_c ? '0 : psc_q + PSC_W'(1);
          cnt_d = (tick_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable wins over everything, including an edge in the same cycle
    if (!bus.enable) begin
      state_d = IDLE;
      psc_d   = '0;
      cnt_d   = '0;
      push_c  = 1'b0;
    end
  end

  assign full_c = (level_q == LVL_W'(DEPTH));
  assign pop_c  = bus.rd_en && rd_valid_q;
  assign wr_c   = push_c && (!full_c || pop_c);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    rd_data_d = '0;
    if (wr_c)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_c && !pop_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_c && !wr_c) begin
      level_d = level_q - LVL_W'(1);
    end
    if (push_c && !wr_c) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
    // Registered head: bypass the entry being written when it becomes the new head
    if (level_d != '0) begin
      rd_data_d = (wr_c && (wr_ptr_q == rd_ptr_d)) ? cnt_q : mem_q[rd_ptr_d];
    end
    rd_valid_d = (level_d != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_c) mem_q[wr_ptr_q] <= cnt_q;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ts_event_reader.sv
// Bench for ts_event_reader: directed table plus random traffic against an interval/queue model.
module tb_ts_event_reader;
  localparam int unsigned P    = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned D    = 4;
  localparam int unsigned MAXV = 32'((64'd1 << W) - 1);

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ts_event_reader_if #(.CNT_W(W), .DEPTH(D)) bus ();
  ts_event_reader #(.PRESCALE(P), .CNT_W(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  ts_event_reader_if #(.CNT_W(4), .DEPTH(4)) bus2 ();
  ts_event_reader #(.PRESCALE(1), .CNT_W(4), .DEPTH(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // Reference model: sampled event history, measurement phase, queue of intervals
  int cyc;
  bit evq[$];
  int mode;      // 0 disabled, 1 waiting for first edge, 2 measuring
  int last;
  int fq[$];
  bit m_ovf;

  typedef struct {
    int exp_level;
    int exp_head;
    bit exp_ovf;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    evq = '{0, 0, 0, 0};
    fq.delete();
    m_ovf = 1'b0;
    mode  = 0;
    last  = 0;
  endtask

  task automatic step();
    bit edg, pop, push, full;
    int v;
    @(posedge clock);
    cyc++;
    evq.push_back(bus.event_in);
    void'(evq.pop_front());
    edg  = evq[1] && !evq[0];
    full = (fq.size() == D);
    pop  = bus.rd_en && (fq.size() != 0);
    push = 1'b0;
    v    = 0;
    if (!bus.enable) begin
      mode = 0;
    end else if (mode == 0) begin
      mode = 1;
    end else if (edg) begin
      if (mode == 2) begin
        push = 1'b1;
        v = (cyc - last) / P;
        if (v > int'(MAXV)) v = int'(MAXV);
      end
      mode = 2;
      last = cyc;
    end
    if (pop) void'(fq.pop_front());
    if (push && full && !pop) m_ovf = 1'b1;
    else begin
      if (push) fq.push_back(v);
      if (bus.clr_ovf) m_ovf = 1'b0;
    end
    #1;
    chk("m_valid", 32'(bus.rd_valid), 32'(fq.size() != 0));
    chk("m_level", 32'(bus.level), 32'(fq.size()));
    chk("m_data", 32'(bus.rd_data), (fq.size() != 0) ? 32'(fq[0]) : 32'd0);
    chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rise(input int gap);
    bus.event_in = 1'b1;
    run(gap / 2);
    bus.event_in = 1'b0;
    run(gap - gap / 2);
  endtask

  task automatic pop_one(input string nm, input int exp);
    chk(nm, 32'(bus.rd_data), 32'(exp));
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 0, 1'b0};
    tbl[1] = '{1, 5, 1'b0};
    tbl[2] = '{2, 5, 1'b0};
    tbl[3] = '{3, 5, 1'b0};
    tbl[4] = '{4, 5, 1'b0};
    tbl[5] = '{4, 5, 1'b1};
    tbl[6] = '{4, 5, 1'b1};

    reset_n = 1'b0;
    bus.enable = 1'b0; bus.event_in = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    bus2.enable = 1'b0; bus2.event_in = 1'b0; bus2.rd_en = 1'b0; bus2.clr_ovf = 1'b0;
    cyc = 0;
    model_reset();
    #23;
    reset_n = 1'b1;
    chk("reset_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_level", 32'(bus.level), 32'd0);
    chk("reset_data", 32'(bus.rd_data), 32'd0);
    chk("reset_ovf", 32'(bus.overflow), 32'd0);

    // Seven rises 20 clocks apart, no reads
    bus.enable = 1'b1;
    run(3);
    for (int i = 0; i < 7; i++) begin
      rise(20);
      chk("tbl_level", 32'(bus.level), 32'(tbl[i].exp_level));
      chk("tbl_head", 32'(bus.rd_data), 32'(tbl[i].exp_head));
      chk("tbl_ovf", 32'(bus.overflow), 32'(tbl[i].exp_ovf));
    end
    for (int i = 0; i < 4; i++) pop_one("drain_data", 5);
    chk("drain_valid", 32'(bus.rd_valid), 32'd0);
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'd0);

    // Fill, then push with a same-cycle pop
    bus.enable = 1'b0; step(); bus.enable = 1'b1; step();
    for (int i = 0; i < 5; i++) rise(20);
    chk("full_level", 32'(bus.level), 32'd4);
    run(4);
    bus.event_in = 1'b1;
    step(); step();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("pushpop_level", 32'(bus.level), 32'd4);
    chk("pushpop_ovf", 32'(bus.overflow), 32'd0);
    run(10); bus.event_in = 1'b0; run(10);
    pop_one("pp_data0", 5);
    pop_one("pp_data1", 5);
    pop_one("pp_data2", 5);
    pop_one("pp_last", 6);
    chk("pp_empty", 32'(bus.rd_valid), 32'd0);

    // Disable mid-interval, re-enable
    bus.enable = 1'b0; step(); bus.enable = 1'b1; step();
    rise(20);
    bus.event_in = 1'b1; run(10);
    bus.event_in = 1'b0; run(2);
    bus.enable = 1'b0; run(3);
    bus.enable = 1'b1; run(5);
    chk("dis_level1", 32'(bus.level), 32'd1);
    rise(20);
    rise(20);
    chk("dis_level2", 32'(bus.level), 32'd2);
    chk("dis_head", 32'(bus.rd_data), 32'd5);

    // Level 2 with overflow set, then async reset pulse
    for (int i = 0; i < 3; i++) rise(20);
    pop_one("pre_rst0", 5);
    pop_one("pre_rst1", 5);
    chk("pre_rst_level", 32'(bus.level), 32'd2);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run(2);
    rise(20);
    run(5);
    chk("post_rst_level", 32'(bus.level), 32'd0);

    // Saturating counter on the narrow instance
    bus2.enable = 1'b1;
    run(2);
    bus2.event_in = 1'b1; run(5); bus2.event_in = 1'b0; run(35);
    bus2.event_in = 1'b1; run(5); bus2.event_in = 1'b0; run(5);
    bus2.event_in = 1'b1; run(3); bus2.event_in = 1'b0; run(5);
    chk("sat_level", 32'(bus2.level), 32'd2);
    chk("sat_data", 32'(bus2.rd_data), 32'd15);
    bus2.rd_en = 1'b1; step(); bus2.rd_en = 1'b0;
    chk("sat_next", 32'(bus2.rd_data), 32'd10);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int gap;
      int hi;
      gap = int'($urandom_range(40, 3));
      hi  = int'($urandom_range(gap - 1, 1));
      bus.event_in = 1'b1;
      for (int c = 0; c < gap; c++) begin
        if (c == hi) bus.event_in = 1'b0;
        bus.rd_en   = ($urandom_range(99) < 30);
        bus.clr_ovf = ($urandom_range(99) < 5);
        bus.enable  = ($urandom_range(199) != 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ts_event_reader.md
Name: ts_event_reader

Overview:
- Receive-side companion to the timescale test modules: samples a timed event signal and measures the interval between successive rising edges.
- Intervals are measured in coarse time units derived from `clock` by a programmable prescaler, which models the unit/precision ratio.
- Measured intervals go into a small first-word-fall-through FIFO that a bench or monitor reads.
- Sits beside the event generator in timescale diagnostics so the dumped intervals can be checked against the expected delays.

Parameters:
- PRESCALE, 1000, clock cycles per time unit (>=1).
- CNT_W, 16, width of interval count and FIFO data.
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable.
- event_in  input  1  asynchronous event signal.
- rd_en  input  1  pop request.
- rd_data  output  CNT_W  interval at FIFO head (valid when rd_valid=1).
- rd_valid  output  1  FIFO non-empty.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky: an interval was dropped because the FIFO was full.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (reset_n=0, async): all of the following go to 0 immediately:
  - sync flops, prescaler, interval counter;
  - FIFO pointers, rd_data, rd_valid, level, overflow;
  - state = IDLE.
- Synchroniser: event_in passes through 2 flops; the third flop holds the previous value.
  - edge = sync2 & ~sync3.
  - An event_in rise sampled at cycle N produces edge in cycle N+2.
- Prescaler: counts 0..PRESCALE-1 while state=RUNNING.
  - tick is asserted when prescaler==PRESCALE-1; the prescaler wraps to 0 in that cycle.
- Interval counter: increments on tick and saturates at 2^CNT_W-1 (no wrap).
- State machine:
  - IDLE: counters held at 0. enable=1 -> ARMED.
  - ARMED: waits for the first edge. edge -> RUNNING with prescaler and counter cleared. No push.
  - RUNNING: on edge, push the interval counter value as registered before this cycle's tick, then clear prescaler and counter. A tick coinciding with the edge is discarded.
  - enable=0 in any state -> IDLE next cycle. Counters are cleared; FIFO contents and overflow are retained.
- Push timing: the pushed entry is visible in rd_data/rd_valid/level one cycle after the edge, i.e. cycle N+3 relative to the event_in sample.
- FIFO (first-word-fall-through):
  - rd_data = head entry; 0 when empty.
  - rd_en with rd_valid=1 pops at the clock edge.
  - rd_en while empty is ignored; no underflow state.
- Push while full:
  - without a pop: entry dropped, overflow set, level unchanged;
  - with a simultaneous pop: both occur, level unchanged, no overflow.
- Push and pop on a non-full, non-empty FIFO: level unchanged.
- Pointers wrap modulo DEPTH; level distinguishes full from empty.
- overflow: set has priority over clr_ovf in the same cycle; otherwise clr_ovf clears it.
- Glitch rule: an event_in high pulse shorter than one clock may be missed. It is never counted twice.
- Reset asserted mid-measurement aborts immediately. After release the block is in IDLE and requires enable plus a fresh first edge.

Test Plan:
- PRESCALE=4, enable=1, event_in rises every 20 clocks, 4 rises -> exactly 3 entries, each rd_data=5, level=3, overflow=0.
- Same stimulus, DEPTH=4, no reads, 7 rises -> level=4 after the 5th rise, overflow=1 after the 6th rise; popping 4 times returns 5,5,5,5 then rd_valid=0.
- FIFO full, with rd_en asserted in the same cycle as an edge push -> level stays 4, overflow stays 0, the new entry appears last.
- CNT_W=4, PRESCALE=1, 40 clocks between rises -> rd_data=15 (saturated).
- Event spacing 20 clocks; drop enable mid-interval, re-enable, 2 further rises -> only 1 new entry (value 5); FIFO contents from before disable are preserved.
- Pulse reset_n low for 1 clock while level=2 and overflow=1 -> rd_valid=0, level=0, overflow=0 immediately; the next single rise pushes nothing.
